uart_rx_deserializer: RTL and testbench

- 8N1-style UART receiver for the serial input pin. Consumes the single-cycle `rx_clk_posedge` oversampling strobe from the UART clock generator: RX_CLKS_PER_BIT strobes per bit time, all logic on `main_clk`.
- Validates the start bit at mid-bit, shifts in data LSB-first at mid-bit sample points and checks the stop bit.
- Delivers each byte through a one-entry valid/ready holding register, with framing-error and overrun strobes.

---
 rtl/uart_rx_deserializer.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer
//
// Receives 8N1-style UART frames from the serial line. Every step is taken on a
// main_clk edge that carries the oversampling strobe. There are
// RX_CLKS_PER_BIT strobes per bit time.
//   - The start bit is confirmed at mid-bit. A line that is high again at that
//     point is treated as a glitch and ignored.
//   - Data bits are sampled once per bit time, LSB first.
//   - The stop bit is checked at mid-stop, and the FSM returns to idle there.
// Each good byte goes to a one-entry valid/ready holding register. A bad stop
// bit pulses frame_err. A good byte that arrives while the holding register is
// full and not being drained is dropped and pulses overrun.
//
// Parameters
//   RX_CLKS_PER_BIT  strobes per bit time (even, >= 4)
//   DATA_BITS        data bits per frame (5..9)
//
// Ports
//   main_clk        in   system clock
//   rst_n           in   asynchronous active-low reset
//   rx_clk_posedge  in   oversampling strobe, one main_clk cycle wide
//   rx              in   asynchronous serial line, idle high
//   data            out  received byte, meaningful while valid=1
//   valid           out  holding register full
//   ready           in   consumer takes data when valid && ready
//   frame_err       out  one-cycle pulse on a bad stop bit
//   overrun         out  one-cycle pulse when a good byte is dropped
// -----------------------------------------------------------------------------
module uart_rx_deserializer #(
   parameter int RX_CLKS_PER_BIT = 8,
   parameter int DATA_BITS       = 8
) (
   input  logic                 main_clk,
   input  logic                 rst_n,
   input  logic                 rx_clk_posedge,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int TICK_W = $clog2(RX_CLKS_PER_BIT);
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(RX_CLKS_PER_BIT/2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RX_CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_RECOVER
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_rx_meta;
   logic                  r_rx_s;
   logic [TICK_W-1:0]     r_tick;
   logic [TICK_W-1:0]     w_tick_nxt;
   logic [BIT_W-1:0]      r_bit;
   logic [BIT_W-1:0]      w_bit_nxt;
   logic [DATA_BITS-1:0]  r_shift;
   logic [DATA_BITS-1:0]  w_shift_nxt;
   logic [DATA_BITS-1:0]  r_data;
   logic                  r_valid;
   logic                  r_frame_err;
   logic                  r_overrun;
   logic                  w_deliver;
   logic                  w_bad_stop;

   // Two-flop synchronizer. It resets to the idle line level so that reset
   // release never looks like a start edge.
   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // FSM state, tick/bit counters and shift register.
   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_tick  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tick  <= w_tick_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   // Nothing advances without a strobe. Once the start bit is confirmed at
   // mid-bit, each later sample falls one full bit time further on, so data
   // and stop bits are all sampled near their centres.
   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_deliver   = 1'b0;
      w_bad_stop  = 1'b0;
      if (rx_clk_posedge) begin
         case (r_state)
            S_IDLE: begin
               if (!r_rx_s) begin
                  w_state_nxt = S_START;
                  w_tick_nxt  = '0;
               end
            end
            S_START: begin
               if (r_tick == TICK_MID) begin
                  if (r_rx_s) begin
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_state_nxt = S_DATA;
                     w_tick_nxt  = '0;
                     w_bit_nxt   = '0;
                  end
               end else begin
                  w_tick_nxt = r_tick + 1'b1;
               end
            end
            S_DATA: begin
               if (r_tick == TICK_LAST) begin
                  // The line sends LSB first. Entering at the MSB leaves the
                  // first bit received in bit 0 after DATA_BITS shifts.
                  w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
                  w_tick_nxt  = '0;
                  w_bit_nxt   = r_bit + 1'b1;
                  if (r_bit == BIT_LAST) begin
                     w_state_nxt = S_STOP;
                  end
               end else begin
                  w_tick_nxt = r_tick + 1'b1;
               end
            end
            S_STOP: begin
               if (r_tick == TICK_LAST) begin
                  w_tick_nxt = '0;
                  if (r_rx_s) begin
                     w_deliver   = 1'b1;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_bad_stop  = 1'b1;
                     w_state_nxt = S_RECOVER;
                  end
               end else begin
                  w_tick_nxt = r_tick + 1'b1;
               end
            end
            S_RECOVER: begin
               // A break keeps the line low. Waiting here for a high line
               // means one break yields one frame_err, not one per frame time.
               if (r_rx_s) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Holding register and status pulses. A delivery in the same cycle as an
   // accept replaces the byte and keeps valid high. A delivery while the byte
   // is held and not accepted drops the new byte and pulses overrun.
   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_bad_stop;
         r_overrun   <= w_deliver && r_valid && !ready;
         if (w_deliver && (!r_valid || ready)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data      = r_data;
   assign valid     = r_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;

   localparam int RXC    = 8;
   localparam int DB     = 8;
   localparam int BITCLK = 32;   // 8 strobes per bit, one strobe every 4 clocks

   logic          main_clk = 1'b0;
   logic          rst_n;
   logic          rx_clk_posedge;
   logic          rx;
   logic [DB-1:0] data;
   logic          valid;
   logic          ready;
   logic          frame_err;
   logic          overrun;

   uart_rx_deserializer #(
      .RX_CLKS_PER_BIT (RXC),
      .DATA_BITS       (DB)
   ) u_dut (
      .main_clk       (main_clk),
      .rst_n          (rst_n),
      .rx_clk_posedge (rx_clk_posedge),
      .rx             (rx),
      .data           (data),
      .valid          (valid),
      .ready          (ready),
      .frame_err      (frame_err),
      .overrun        (overrun)
   );

   always #5 main_clk = ~main_clk;

   int         n_vec   = 0;
   int         n_miss  = 0;
   int         cyc     = 0;
   int         n_ferr  = 0;
   int         n_ovr   = 0;
   int         n_vrise = 0;
   int         acc_cnt = 0;
   logic [7:0] last_acc = 8'h00;
   logic [7:0] acc_q[$];
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] din;
      logic       stopb;
      logic       rdy;
      logic       e_valid;
      logic [7:0] e_data;
      int         e_ferr;
      int         e_ovr;
      int         e_acc;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Each call moves to the next negedge. The values set afterwards apply to
   // the following posedge, numbered cyc. The strobe is high on every 4th edge.
   task automatic step(input int n);
      repeat (n) begin
         @(negedge main_clk);
         cyc++;
         rx_clk_posedge = (cyc % 4 == 0);
      end
   endtask

   task automatic align();
      while (cyc % 4 != 2) step(1);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stopb);
      rx = 1'b0;
      step(BITCLK);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         step(BITCLK);
      end
      rx = stopb;
      step(BITCLK);
      rx = 1'b1;
   endtask

   // Monitor: pulse counts, accepted bytes, and data held stable while
   // valid is high and not accepted.
   initial begin
      logic       pv;
      logic       pr;
      logic [7:0] pd;
      pv = 1'b0;
      pr = 1'b0;
      pd = 8'h00;
      forever begin
         @(negedge main_clk);
         #2;
         if (frame_err) n_ferr++;
         if (overrun) n_ovr++;
         if (valid && !pv) n_vrise++;
         if (pv && !pr && valid) chk("hold_stable", int'(data), int'(pd));
         if (valid && ready) begin
            acc_cnt++;
            last_acc = data;
            acc_q.push_back(data);
         end
         pv = valid;
         pr = ready;
         pd = data;
      end
   end

   initial begin
      repeat (200000) @(posedge main_clk);
      $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
      $fatal(1);
   end

   initial begin
      int         f0;
      int         o0;
      int         a0;
      int         v0;
      int         e_ferr;
      int         e_ovr;
      logic       m_full;
      logic [7:0] m_data;
      logic [7:0] b;
      logic       stopb;
      logic       rdy;

      tbl[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55, 0, 0, 1};
      tbl[1] = '{8'h81, 1'b0, 1'b1, 1'b0, 8'h00, 1, 0, 0};
      tbl[2] = '{8'h7E, 1'b1, 1'b1, 1'b0, 8'h7E, 0, 0, 1};
      tbl[3] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 0, 0, 0};
      tbl[4] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 0, 1, 0};
      tbl[5] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 0, 0, 2};
      tbl[6] = '{8'hC9, 1'b1, 1'b0, 1'b1, 8'hC9, 0, 0, 0};
      tbl[7] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hC9, 1, 0, 0};
      tbl[8] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 2};
      tbl[9] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 0, 0, 1};

      rst_n          = 1'b0;
      rx             = 1'b1;
      ready          = 1'b0;
      rx_clk_posedge = 1'b0;
      step(3);
      #1;
      chk("rst_valid", int'(valid), 0);
      chk("rst_data", int'(data), 0);
      chk("rst_frame_err", int'(frame_err), 0);
      chk("rst_overrun", int'(overrun), 0);
      rst_n = 1'b1;
      step(40);

      // Table-driven frames.
      for (int i = 0; i < 10; i++) begin
         f0 = n_ferr; o0 = n_ovr; a0 = acc_cnt; v0 = n_vrise;
         ready = tbl[i].rdy;
         send_frame(tbl[i].din, tbl[i].stopb);
         step(BITCLK);
         chk($sformatf("t%0d_valid", i), int'(valid), int'(tbl[i].e_valid));
         if (tbl[i].e_valid) chk($sformatf("t%0d_data", i), int'(data), int'(tbl[i].e_data));
         chk($sformatf("t%0d_ferr", i), n_ferr - f0, tbl[i].e_ferr);
         chk($sformatf("t%0d_ovr", i), n_ovr - o0, tbl[i].e_ovr);
         chk($sformatf("t%0d_acc", i), acc_cnt - a0, tbl[i].e_acc);
         if (tbl[i].e_acc > 0) chk($sformatf("t%0d_acc_data", i), int'(last_acc), int'(tbl[i].e_data));
         chk($sformatf("t%0d_vrise", i), n_vrise - v0,
             (tbl[i].stopb && tbl[i].e_ovr == 0) ? 1 : 0);
      end

      // Held byte survives a long wait, then goes on a one-cycle accept.
      ready = 1'b0;
      a0 = acc_cnt;
      send_frame(8'hA3, 1'b1);
      step(4);
      chk("hold_valid0", int'(valid), 1);
      chk("hold_data0", int'(data), 'hA3);
      step(20);
      chk("hold_valid1", int'(valid), 1);
      chk("hold_data1", int'(data), 'hA3);
      ready = 1'b1;
      step(1);
      ready = 1'b0;
      step(1);
      chk("hold_valid_after", int'(valid), 0);
      chk("hold_acc_cnt", acc_cnt - a0, 1);
      chk("hold_acc_data", int'(last_acc), 'hA3);

      // A short low pulse is rejected, then a real frame follows.
      ready = 1'b1;
      f0 = n_ferr; v0 = n_vrise; a0 = acc_cnt;
      align();
      rx = 1'b0;
      step(8);
      rx = 1'b1;
      step(64);
      chk("glitch_vrise", n_vrise - v0, 0);
      chk("glitch_ferr", n_ferr - f0, 0);
      chk("glitch_valid", int'(valid), 0);
      send_frame(8'h3C, 1'b1);
      step(BITCLK);
      chk("glitch_next_acc", acc_cnt - a0, 1);
      chk("glitch_next_data", int'(last_acc), 'h3C);

      // A long break gives exactly one frame error.
      f0 = n_ferr; v0 = n_vrise;
      rx = 1'b0;
      step(30 * BITCLK);
      rx = 1'b1;
      step(64);
      chk("break_ferr", n_ferr - f0, 1);
      chk("break_vrise", n_vrise - v0, 0);
      chk("break_valid", int'(valid), 0);
      send_frame(8'h5A, 1'b1);
      step(BITCLK);
      chk("break_next_data", int'(last_acc), 'h5A);

      // Back-to-back frames with ready low: the second is dropped. Edges are
      // aligned so that the mid-stop strobe of a frame starting at edge c lands
      // on edge c+306 (2 sync + 4*(4+8*8+8) strobe edges).
      ready = 1'b0;
      o0 = n_ovr; a0 = acc_cnt;
      align();
      send_frame(8'h11, 1'b1);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (306) @(negedge main_clk);
            #2;
            chk("ovr_pre_pulse", int'(overrun), 0);
            chk("ovr_pre_data", int'(data), 'h11);
            @(negedge main_clk);
            #2;
            chk("ovr_pulse", int'(overrun), 1);
            chk("ovr_valid", int'(valid), 1);
            chk("ovr_data", int'(data), 'h11);
            @(negedge main_clk);
            #2;
            chk("ovr_pulse_end", int'(overrun), 0);
         end
      join
      step(4);
      chk("ovr_count", n_ovr - o0, 1);
      chk("ovr_acc", acc_cnt - a0, 0);
      ready = 1'b1;
      step(1);
      ready = 1'b0;
      step(2);
      chk("ovr_flush", int'(last_acc), 'h11);

      // Same again, with ready high only on the delivery edge of the 2nd byte.
      o0 = n_ovr; a0 = acc_cnt;
      align();
      send_frame(8'h11, 1'b1);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (306) @(negedge main_clk);
            ready = 1'b1;
            #2;
            chk("swap_pre_data", int'(data), 'h11);
            chk("swap_pre_valid", int'(valid), 1);
            @(negedge main_clk);
            ready = 1'b0;
            #2;
            chk("swap_valid", int'(valid), 1);
            chk("swap_data", int'(data), 'h22);
            chk("swap_overrun", int'(overrun), 0);
         end
      join
      step(4);
      chk("swap_ovr_count", n_ovr - o0, 0);
      chk("swap_acc", acc_cnt - a0, 1);
      chk("swap_acc_data", int'(last_acc), 'h11);
      ready = 1'b1;
      step(1);
      ready = 1'b0;
      step(2);
      chk("swap_flush", int'(last_acc), 'h22);

      // Reset during data bit 4 with a byte held.
      send_frame(8'h5A, 1'b1);
      step(8);
      chk("prerst_valid", int'(valid), 1);
      chk("prerst_data", int'(data), 'h5A);
      align();
      b = 8'hC9;
      rx = 1'b0;
      step(BITCLK);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         step(BITCLK);
      end
      rx = b[4];
      step(16);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", int'(valid), 0);
      chk("midrst_data", int'(data), 0);
      chk("midrst_ferr", int'(frame_err), 0);
      chk("midrst_ovr", int'(overrun), 0);
      step(3);
      rst_n = 1'b1;
      rx = 1'b1;
      step(64);
      chk("postrst_valid", int'(valid), 0);
      ready = 1'b1;
      a0 = acc_cnt;
      send_frame(8'hC9, 1'b1);
      step(BITCLK);
      chk("postrst_acc", acc_cnt - a0, 1);
      chk("postrst_data", int'(last_acc), 'hC9);
      chk("postrst_valid2", int'(valid), 0);

      // Randomized frames against a frame-level model of the holding register.
      acc_q.delete();
      exp_q.delete();
      m_full = 1'b0;
      m_data = 8'h00;
      e_ferr = n_ferr;
      e_ovr  = n_ovr;
      for (int k = 0; k < 40; k++) begin
         b     = 8'($urandom);
         stopb = ($urandom_range(0, 4) != 0);
         rdy   = 1'($urandom_range(0, 1));
         ready = rdy;
         if (rdy && m_full) begin
            exp_q.push_back(m_data);
            m_full = 1'b0;
         end
         send_frame(b, stopb);
         if (!stopb) e_ferr++;
         else if (m_full) e_ovr++;
         else if (rdy) exp_q.push_back(b);
         else begin
            m_full = 1'b1;
            m_data = b;
         end
         step(BITCLK + int'($urandom_range(0, 40)));
         chk($sformatf("r%0d_valid", k), int'(valid), int'(m_full));
         if (m_full) chk($sformatf("r%0d_data", k), int'(data), int'(m_data));
         chk($sformatf("r%0d_ferr", k), n_ferr, e_ferr);
         chk($sformatf("r%0d_ovr", k), n_ovr, e_ovr);
         chk($sformatf("r%0d_acc_n", k), acc_q.size(), exp_q.size());
         while (acc_q.size() > 0 && exp_q.size() > 0) begin
            chk($sformatf("r%0d_acc_byte", k), int'(acc_q.pop_front()), int'(exp_q.pop_front()));
         end
         acc_q.delete();
         exp_q.delete();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
